// File: rtl/hdmi_tx_encoder_if.sv
// Pixel-side and symbol-side signal bundle for the TMDS transmit encoder.
interface hdmi_tx_encoder_if;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       vde;
  logic       hsync;
  logic       vsync;
  logic [3:0] cntrl;
  logic [9:0] tmds_red;
  logic [9:0] tmds_green;
  logic [9:0] tmds_blue;
  logic [9:0] tmds_clk_word;
  logic       vde_out;

  modport master (
    output red, green, blue, vde, hsync, vsync, cntrl,
    input  tmds_red, tmds_green, tmds_blue, tmds_clk_word, vde_out
  );

  modport slave (
    input  red, green, blue, vde, hsync, vsync, cntrl,
    output tmds_red, tmds_green, tmds_blue, tmds_clk_word, vde_out
  );
endinterface

// File: rtl/hdmi_tx_encoder.sv
// DVI 1.0 TMDS encoder: three independent channels sharing a two-stage
// pipeline (transition minimisation, then DC balance with running disparity).
// Channel index 0 is blue, 1 is green, 2 is red.
module hdmi_tx_encoder #(
  parameter logic [9:0] CLK_WORD = 10'b0000011111
) (
  input logic pixclk,
  input logic rst,
  hdmi_tx_encoder_if.slave bus
);

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  logic [2:0][7:0] data_in;
  logic [2:0][1:0] ctrl_in;

  logic [2:0][8:0] qm_next;
  logic [2:0][8:0] qm_s1;
  logic [2:0][1:0] ctrl_s1;
  logic            de_s1;

  logic [2:0][9:0] sym_next;
  logic [2:0][4:0] cnt_next;
  logic [2:0][9:0] sym_s2;
  logic [2:0][4:0] cnt_s2;
  logic            de_s2;
  logic [9:0]      clk_word_q;

  assign data_in = {bus.red, bus.green, bus.blue};
  assign ctrl_in = {bus.cntrl[3:2], bus.cntrl[1:0], {bus.vsync, bus.hsync}};

  function automatic logic [8:0] minimize(input logic [7:0] d);
    logic [3:0] n1;
    logic       xnor_mode;
    logic [8:0] q;
    n1 = 4'($countones(d));
    xnor_mode = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = xnor_mode ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~xnor_mode;
    return q;
  endfunction

  function automatic logic [9:0] token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOKEN_00;
      2'b01:   t = TOKEN_01;
      2'b10:   t = TOKEN_10;
      default: t = TOKEN_11;
    endcase
    return t;
  endfunction

  // Stage 1 combinational: transition-minimised 9-bit word per channel.
  always_comb begin
    qm_next = '0;
    for (int c = 0; c < 3; c++) begin
      qm_next[c] = minimize(data_in[c]);
    end
  end

  // Stage 1 register: q_m words plus de and control bits, cleared to blanking on reset.
  always_ff @(posedge pixclk) begin
    if (!rst) begin
      qm_s1   <= '0;
      ctrl_s1 <= '0;
      de_s1   <= 1'b0;
    end else begin
      qm_s1   <= qm_next;
      ctrl_s1 <= ctrl_in;
      de_s1   <= bus.vde;
    end
  end

  // Stage 2 combinational: DC balancing against each channel's running disparity.
  always_comb begin
    logic signed [5:0] cnt_ext;
    logic signed [5:0] n1;
    logic signed [5:0] diff;
    logic signed [5:0] delta;
    logic [8:0]        q;
    sym_next = '0;
    cnt_next = '0;
    for (int c = 0; c < 3; c++) begin
      q       = qm_s1[c];
      cnt_ext = {cnt_s2[c][4], cnt_s2[c]};
      n1      = 6'($countones(q[7:0]));
      diff    = (n1 <<< 1) - 6'sd8;
      delta   = 6'sd0;
      if (!de_s1) begin
        sym_next[c] = token(ctrl_s1[c]);
      end else if ((cnt_ext == 6'sd0) || (n1 == 6'sd4)) begin
        sym_next[c] = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
        delta       = q[8] ? diff : -diff;
      end else if (((cnt_ext > 6'sd0) && (n1 > 6'sd4)) ||
                   ((cnt_ext < 6'sd0) && (n1 < 6'sd4))) begin
        sym_next[c] = {1'b1, q[8], ~q[7:0]};
        delta       = (q[8] ? 6'sd2 : 6'sd0) - diff;
      end else begin
        sym_next[c] = {1'b0, q[8], q[7:0]};
        delta       = diff - (q[8] ? 6'sd0 : 6'sd2);
      end
      cnt_next[c] = de_s1 ? 5'(cnt_ext + delta) : 5'd0;
    end
  end

  // Stage 2 register: output symbols, disparity counters, aligned vde and clock word.
  always_ff @(posedge pixclk) begin
    if (!rst) begin
      sym_s2     <= {3{TOKEN_00}};
      cnt_s2     <= '0;
      de_s2      <= 1'b0;
      clk_word_q <= CLK_WORD;
    end else begin
      sym_s2     <= sym_next;
      cnt_s2     <= cnt_next;
      de_s2      <= de_s1;
      clk_word_q <= CLK_WORD;
    end
  end

  assign bus.tmds_blue     = sym_s2[0];
  assign bus.tmds_green    = sym_s2[1];
  assign bus.tmds_red      = sym_s2[2];
  assign bus.vde_out       = de_s2;
  assign bus.tmds_clk_word = clk_word_q;

endmodule

// File: tb/tb_hdmi_tx_encoder.sv
// Scoreboard bench for hdmi_tx_encoder: a behavioural TMDS model produces the
// expected symbols at issue time; a monitor pops them when due and also decodes
// the DUT symbols back to pixels/control bits.
module tb_hdmi_tx_encoder;

  localparam logic [9:0] CLK_WORD = 10'b0000011111;
  localparam logic [9:0] TOK0 = 10'h354;
  localparam logic [9:0] TOK1 = 10'h0AB;
  localparam logic [9:0] TOK2 = 10'h154;
  localparam logic [9:0] TOK3 = 10'h2AB;

  typedef struct {
    int              due;
    logic [2:0][9:0] sym;
    logic            vde;
    logic            decodable;
    logic [2:0][7:0] data;
    logic [2:0][1:0] ctl;
    logic            gold_en;
    logic [9:0]      gold;
  } exp_t;

  logic  pixclk = 1'b0;
  logic  rst = 1'b0;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    mcnt [3];
  exp_t  sbq [$];
  string ch_name [3] = '{"blue", "green", "red"};

  hdmi_tx_encoder_if bus ();

  hdmi_tx_encoder #(.CLK_WORD(CLK_WORD)) dut (
    .pixclk (pixclk),
    .rst    (rst),
    .bus    (bus)
  );

  // Free-running pixel clock.
  always #5 pixclk = ~pixclk;

  // Count rising edges so expectations can be tagged with the cycle they are due.
  always @(posedge pixclk) cyc <= cyc + 1;

  function automatic logic [9:0] ref_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOK0;
      2'b01:   t = TOK1;
      2'b10:   t = TOK2;
      default: t = TOK3;
    endcase
    return t;
  endfunction

  function automatic logic [9:0] ref_encode(input int ch, input logic [7:0] d);
    int         ones, n1, n0, disp;
    bit         inv_mode;
    logic [8:0] qm;
    logic [9:0] out;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    inv_mode = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = inv_mode ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !inv_mode;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
    n0 = 8 - n1;
    disp = mcnt[ch];
    if (disp == 0 || n1 == n0) begin
      out = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disp += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((disp > 0 && n1 > n0) || (disp < 0 && n0 > n1)) begin
      out = {1'b1, qm[8], ~qm[7:0]};
      disp += 2 * int'(qm[8]) + (n0 - n1);
    end else begin
      out = {1'b0, qm[8], qm[7:0]};
      disp += -2 * int'(!qm[8]) + (n1 - n0);
    end
    mcnt[ch] = disp;
    return out;
  endfunction

  function automatic logic [7:0] decode_data(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic logic [2:0] decode_ctrl(input logic [9:0] s);
    logic [2:0] r;
    case (s)
      TOK0:    r = 3'b100;
      TOK1:    r = 3'b101;
      TOK2:    r = 3'b110;
      TOK3:    r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    case ($urandom_range(0, 7))
      0:       b = 8'h00;
      1:       b = 8'hFF;
      default: b = 8'($urandom);
    endcase
    return b;
  endfunction

  task automatic apply_stimulus(input logic rst_n, input logic de,
                                input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                input logic hs, input logic vs, input logic [3:0] cn,
                                input logic gold_en, input logic [9:0] gold);
    exp_t e;
    @(negedge pixclk);
    rst = rst_n;
    bus.red = r;
    bus.green = g;
    bus.blue = b;
    bus.vde = de;
    bus.hsync = hs;
    bus.vsync = vs;
    bus.cntrl = cn;
    e.data = {r, g, b};
    e.ctl = {cn[3:2], cn[1:0], {vs, hs}};
    e.gold_en = gold_en;
    e.gold = gold;
    if (!rst_n) begin
      sbq.delete();
      for (int ch = 0; ch < 3; ch++) mcnt[ch] = 0;
      e.sym = {3{TOK0}};
      e.vde = 1'b0;
      e.decodable = 1'b0;
      e.gold_en = 1'b0;
      e.due = cyc + 1;
      sbq.push_back(e);
      e.due = cyc + 2;
      sbq.push_back(e);
    end else begin
      e.vde = de;
      e.decodable = 1'b1;
      e.due = cyc + 2;
      for (int ch = 0; ch < 3; ch++) begin
        if (de) begin
          e.sym[ch] = ref_encode(ch, e.data[ch]);
        end else begin
          mcnt[ch] = 0;
          e.sym[ch] = ref_token(e.ctl[ch]);
        end
      end
      sbq.push_back(e);
    end
  endtask

  task automatic random_pixel(input logic rst_n, input logic de);
    apply_stimulus(rst_n, de, rand_byte(), rand_byte(), rand_byte(),
                   1'($urandom), 1'($urandom), 4'($urandom), 1'b0, 10'h000);
  endtask

  task automatic check_output(input exp_t e);
    logic [2:0][9:0] act;
    logic [2:0]      dc;
    act = {bus.tmds_red, bus.tmds_green, bus.tmds_blue};
    for (int ch = 0; ch < 3; ch++) begin
      checks++;
      if (act[ch] !== e.sym[ch]) begin
        errors++;
        $display("[TB] FAIL sym_%s cycle %0d: got %h expected %h", ch_name[ch], cyc, act[ch], e.sym[ch]);
      end
    end
    checks++;
    if (bus.vde_out !== e.vde) begin
      errors++;
      $display("[TB] FAIL vde_out cycle %0d: got %b expected %b", cyc, bus.vde_out, e.vde);
    end
    checks++;
    if (bus.tmds_clk_word !== CLK_WORD) begin
      errors++;
      $display("[TB] FAIL clk_word cycle %0d: got %h expected %h", cyc, bus.tmds_clk_word, CLK_WORD);
    end
    if (e.gold_en) begin
      checks++;
      if (bus.tmds_blue !== e.gold) begin
        errors++;
        $display("[TB] FAIL gold_blue cycle %0d: got %h expected %h", cyc, bus.tmds_blue, e.gold);
      end
    end
    if (e.decodable) begin
      for (int ch = 0; ch < 3; ch++) begin
        checks++;
        if (e.vde) begin
          if (decode_data(act[ch]) !== e.data[ch]) begin
            errors++;
            $display("[TB] FAIL decode_%s cycle %0d: got %h expected %h", ch_name[ch], cyc,
                     decode_data(act[ch]), e.data[ch]);
          end
        end else begin
          dc = decode_ctrl(act[ch]);
          if (dc !== {1'b1, e.ctl[ch]}) begin
            errors++;
            $display("[TB] FAIL ctrl_%s cycle %0d: got %b expected 1%b", ch_name[ch], cyc, dc, e.ctl[ch]);
          end
        end
      end
    end
  endtask

  // Monitor: shortly after each rising edge, compare every expectation that is now due.
  initial begin
    forever begin
      @(posedge pixclk);
      #2;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        exp_t e;
        e = sbq.pop_front();
        check_output(e);
      end
    end
  end

  // Stimulus: reset, directed tokens and disparity cases, random video, mid-line reset.
  initial begin
    logic [9:0] tok_gold [4];
    logic [1:0] kk;
    logic       de;
    int         run;
    tok_gold = '{TOK0, TOK1, TOK2, TOK3};
    for (int ch = 0; ch < 3; ch++) mcnt[ch] = 0;
    bus.red = '0; bus.green = '0; bus.blue = '0; bus.vde = 1'b0;
    bus.hsync = 1'b0; bus.vsync = 1'b0; bus.cntrl = '0;

    repeat (3) random_pixel(1'b0, 1'($urandom));

    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      apply_stimulus(1'b1, 1'b0, rand_byte(), rand_byte(), rand_byte(),
                     kk[0], kk[1], {kk, kk}, 1'b1, tok_gold[k]);
    end

    repeat (2) random_pixel(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, rand_byte(), rand_byte(), 8'h00, 1'b0, 1'b0, 4'h0, 1'b1, 10'h100);
    apply_stimulus(1'b1, 1'b1, rand_byte(), rand_byte(), 8'h00, 1'b0, 1'b0, 4'h0, 1'b1, 10'h3FF);
    apply_stimulus(1'b1, 1'b1, rand_byte(), rand_byte(), 8'h00, 1'b0, 1'b0, 4'h0, 1'b1, 10'h100);

    repeat (2) random_pixel(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, rand_byte(), rand_byte(), 8'hFF, 1'b0, 1'b0, 4'h0, 1'b1, 10'h200);

    de = 1'b1;
    run = 0;
    for (int i = 0; i < 1000; i++) begin
      if (run == 0) begin
        de = ~de;
        run = de ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
      end
      run--;
      random_pixel(1'b1, de);
    end

    repeat (10) random_pixel(1'b1, 1'b1);
    random_pixel(1'b0, 1'b1);
    repeat (10) random_pixel(1'b1, 1'b1);

    repeat (4) random_pixel(1'b1, 1'b0);
    for (int t = 0; t < 10 && sbq.size() > 0; t++) @(posedge pixclk);
    #3;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_tx_encoder.md
# hdmi_tx_encoder

Transmit-side TMDS encoder for the HDMI/DVI path. Accepts one pixel per `pixclk` (8-bit R/G/B, sync, data-enable, auxiliary control bits) and produces three 10-bit TMDS symbols per clock using DVI 1.0 encoding with per-channel running disparity. It also produces the clock-channel word. Its output feeds the 10:1 serializer and is bit-compatible with `hdmi_rx`/`TMDS_decoder`: symbols are transmitted LSB first, and the control-bit mapping matches the receiver.

## Interface
Parameters:
- `CLK_WORD`, default 10'b0000011111: constant word emitted on the clock channel.

Ports:
- `pixclk`  in  1  pixel clock; the only clock.
- `rst`  in  1  synchronous, active-low reset.
- `red`, `green`, `blue`  in  8 each  pixel data, sampled when `vde`=1.
- `vde`  in  1  video data enable.
- `hsync`, `vsync`  in  1 each  sent as blue-channel C0/C1 during blanking.
- `cntrl`  in  4  `cntrl[1:0]` is green C1:C0; `cntrl[3:2]` is red C1:C0.
- `tmds_red`, `tmds_green`, `tmds_blue`  out  10 each  encoded symbols, registered.
- `tmds_clk_word`  out  10  equals `CLK_WORD`, registered.
- `vde_out`  out  1  `vde` delayed to align with the symbols.

## Operation
- Three identical channel encoders share one 2-stage pipeline.
- Per channel, stage 1 (registered): transition minimisation.
  - Let N1(D) be the popcount of the data byte.
  - XNOR mode when N1(D)>4, or when N1(D)==4 and D[0]==0:
    - q_m[0]=D[0]; q_m[i]=~(q_m[i-1]^D[i]) for i=1..7; q_m[8]=0.
  - Otherwise XOR mode: q_m[i]=q_m[i-1]^D[i]; q_m[8]=1.
  - Stage 1 also registers `vde` and the 2 control bits.
- Per channel, stage 2 (registered): DC balance.
  - Definitions: n1 = popcount of q_m[7:0]; n0 = 8−n1; `cnt` = 5-bit signed running disparity.
  - If de=1 and (cnt==0 or n1==n0):
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1−n0) : (n0−n1).
  - Else if de=1 and ((cnt>0 and n1>n0) or (cnt<0 and n0>n1)):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2·q_m[8] + (n0−n1).
  - Else if de=1:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += −2·(~q_m[8]) + (n1−n0).
  - If de=0: cnt ← 0, and out is the control token for {C1,C0}:
    - 00 → 10'b1101010100
    - 01 → 10'b0010101011
    - 10 → 10'b0101010100
    - 11 → 10'b1010101011
- `cnt` stays within −10..+10, so a 5-bit signed register cannot overflow. Compute in at least 6-bit signed and truncate.
- Each channel keeps its own `cnt`; the channels are fully independent.

## Timing
- Latency is 2 `pixclk` cycles from input sample to `tmds_*`/`vde_out`. All outputs are aligned.
- Throughput: one symbol per channel per clock, with no stalls.
- On `rst`=0 at a rising edge:
  - All `tmds_*` ← 10'b1101010100 (control token 00).
  - `vde_out` ← 0, all `cnt` ← 0, and both pipeline stages are cleared to de=0, ctrl=00.
  - `tmds_clk_word` ← `CLK_WORD`.
- Reset asserted mid-line takes effect at the next edge regardless of pipeline contents. After release, the first valid output appears 2 cycles after the first sampled input.
- A `vde` 1→0 transition clears `cnt` at the cycle the de=0 word reaches stage 2. On 0→1, encoding starts from cnt=0.
- Control inputs are sampled every cycle but only affect the output when de=0 at stage 2.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with random inputs → all `tmds_*`=0x354, `vde_out`=0, `tmds_clk_word`=0x01F.
- Control tokens: `vde`=0, step {vsync,hsync} through 00/01/10/11 → `tmds_blue` = 0x354, 0x0AB, 0x154, 0x2AB two cycles later. Repeat via `cntrl` for the green and red channels.
- Disparity sequence: after blanking, present blue=0x00 for 3 pixels → `tmds_blue` = 0x100, 0x3FF, 0x100; internal cnt = −8, +2, −6.
- XNOR path: after blanking, blue=0xFF for one pixel → `tmds_blue`=0x200, cnt=−8.
- Loopback: feed 1000 random pixels with random blanking intervals, serialize LSB first into `hdmi_rx` → decoded RGB/sync/`cntrl` match the stimulus exactly. Running disparity is never outside ±10.
- Mid-line reset: assert `rst`=0 for 1 cycle during active video → next outputs are 0x354; encoding restarts from cnt=0 and matches the reference model.
